// File: rtl/score_time_pkg.sv
// score_time_pkg
// Shared types and constants for the score/timer counter.
//   bcd_digit_t  : one BCD digit
//   bcd3_t       : three BCD digits, hundreds in the top nibble
//   game_state_e : game run/expire state
//   BCD3_*       : three-digit BCD constants used as operands and limits
//   bcd2_valid() : true when both nibbles of a two-digit BCD value are 0..9
package score_time_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hundreds;
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd3_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_EXPIRED  = 2'd2
    } game_state_e;

    localparam bcd3_t BCD3_MAX  = 12'h999;
    localparam bcd3_t BCD3_ZERO = 12'h000;
    localparam bcd3_t BCD3_ONE  = 12'h001;
    localparam bcd3_t BCD3_NINE = 12'h009;
    localparam bcd3_t BCD3_TEN  = 12'h010;

    function automatic logic bcd2_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd3_addsub.sv
// bcd3_addsub
// Combinational three-digit BCD add or subtract with clamping.
// Ports:
//   a_i   [11:0] in  first operand, three BCD digits
//   b_i   [11:0] in  second operand, three BCD digits
//   sub_i        in  0: y = a + b (saturates at 999), 1: y = a - b (floors at 000)
//   y_o   [11:0] out result, three BCD digits
module bcd3_addsub
    import score_time_pkg::*;
(
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    input  logic        sub_i,
    output logic [11:0] y_o
);

    logic [2:0][3:0] a_dig;
    logic [2:0][3:0] b_dig;
    logic [2:0][3:0] r_dig;
    logic [4:0]      acc;
    logic            cy;

    // Ripple digit by digit from the ones place; cy is carry when adding and
    // borrow when subtracting. A carry/borrow out of the hundreds digit means
    // the true result left 000..999, so clamp.
    always_comb begin
        a_dig = a_i;
        b_dig = b_i;
        r_dig = '0;
        acc   = '0;
        cy    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!sub_i) begin
                acc = {1'b0, a_dig[i]} + {1'b0, b_dig[i]} + {4'd0, cy};
                if (acc > 5'd9) begin
                    acc = acc - 5'd10;
                    cy  = 1'b1;
                end else begin
                    cy  = 1'b0;
                end
            end else begin
                // A negative digit result shows up as bit 4 set.
                acc = {1'b0, a_dig[i]} - {1'b0, b_dig[i]} - {4'd0, cy};
                if (acc[4]) begin
                    acc = acc + 5'd10;
                    cy  = 1'b1;
                end else begin
                    cy  = 1'b0;
                end
            end
            r_dig[i] = acc[3:0];
        end
        if (cy) begin
            y_o = sub_i ? BCD3_ZERO : BCD3_MAX;
        end else begin
            y_o = r_dig;
        end
    end

endmodule

// File: rtl/score_time_counter.sv
// score_time_counter
// Game score (3 BCD digits) and one-second countdown timer (3 BCD digits)
// with an IDLE / RUNNING / EXPIRED state machine.
// Optional feature: define TIMER_BONUS_EN to honour time_bonus (+10 s).
// Ports:
//   clk, resetN (async, active-low)
//   start       pulse: clear score, load timer, enter RUNNING (highest priority)
//   pause       level: freeze prescaler/timer, block add_points and time_bonus
//   add_points  pulse: add points_bcd (two BCD digits) to score, saturating
//   time_bonus  pulse: add 10 s to timer (TIMER_BONUS_EN only)
//   digit_score_*, digit_time_*  registered BCD digits
//   running / time_up            high in RUNNING / EXPIRED
module score_time_counter
    import score_time_pkg::*;
#(
    parameter int          CLKS_PER_SEC   = 31_500_000,
    parameter logic [11:0] START_TIME_BCD = 12'h120
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       pause,
    input  logic       add_points,
    input  logic [7:0] points_bcd,
    input  logic       time_bonus,
    output logic [3:0] digit_score_ones,
    output logic [3:0] digit_score_tens,
    output logic [3:0] digit_score_hundreds,
    output logic [3:0] digit_time_ones,
    output logic [3:0] digit_time_tens,
    output logic [3:0] digit_time_hundreds,
    output logic       running,
    output logic       time_up
);

    localparam int            PW         = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

    game_state_e   state_q, state_d;
    bcd3_t         score_q, score_d;
    bcd3_t         timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;

    logic          active;
    logic          tick;
    logic          add_ok;
    logic          timer_evt;
    logic          timer_sub;
    bcd3_t         timer_op;
    bcd3_t         score_sum;
    bcd3_t         timer_res;

    assign active = (state_q == ST_RUNNING) && !pause;
    assign tick   = active && (presc_q == PRESC_LAST);
    // A malformed points value drops the whole event rather than a digit.
    assign add_ok = active && add_points && bcd2_valid(points_bcd);

`ifdef TIMER_BONUS_EN
    logic bonus;
    assign bonus     = active && time_bonus;
    assign timer_evt = tick || bonus;
    // Tick plus bonus is applied as one +9 so saturation and expiry see the
    // net change; a bonus therefore always keeps the timer off 000.
    assign timer_sub = !bonus;
    assign timer_op  = !bonus ? BCD3_ONE : (tick ? BCD3_NINE : BCD3_TEN);
`else
    logic unused_time_bonus;
    assign unused_time_bonus = time_bonus;
    assign timer_evt = tick;
    assign timer_sub = 1'b1;
    assign timer_op  = BCD3_ONE;
`endif

    bcd3_addsub u_score_add (
        .a_i   (score_q),
        .b_i   ({4'd0, points_bcd}),
        .sub_i (1'b0),
        .y_o   (score_sum)
    );

    bcd3_addsub u_timer_step (
        .a_i   (timer_q),
        .b_i   (timer_op),
        .sub_i (timer_sub),
        .y_o   (timer_res)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            score_q <= BCD3_ZERO;
            timer_q <= START_TIME_BCD;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        timer_d = timer_q;
        presc_d = presc_q;
        if (start) begin
            state_d = ST_RUNNING;
            score_d = BCD3_ZERO;
            timer_d = START_TIME_BCD;
            presc_d = '0;
        end else if (state_q == ST_RUNNING) begin
            if (add_ok) begin
                score_d = score_sum;
            end
            if (timer_evt) begin
                timer_d = timer_res;
            end
            if (tick && (timer_res == BCD3_ZERO)) begin
                state_d = ST_EXPIRED;
            end
            if (!pause) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
        end
    end

    assign digit_score_ones     = score_q.ones;
    assign digit_score_tens     = score_q.tens;
    assign digit_score_hundreds = score_q.hundreds;
    assign digit_time_ones      = timer_q.ones;
    assign digit_time_tens      = timer_q.tens;
    assign digit_time_hundreds  = timer_q.hundreds;
    assign running              = (state_q == ST_RUNNING);
    assign time_up              = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_score_time_counter.sv
module tb_score_time_counter;

    localparam int N = 4;
`ifdef TIMER_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN;
    logic       start, pause, add_points, time_bonus;
    logic [7:0] points_bcd;

    logic [3:0] a_s1, a_s10, a_s100, a_t1, a_t10, a_t100;
    logic       a_run, a_up;
    logic [3:0] b_s1, b_s10, b_s100, b_t1, b_t10, b_t100;
    logic       b_run, b_up;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    score_time_counter #(.CLKS_PER_SEC(N), .START_TIME_BCD(12'h003)) dut_a (
        .clk(clk), .resetN(resetN), .start(start), .pause(pause),
        .add_points(add_points), .points_bcd(points_bcd), .time_bonus(time_bonus),
        .digit_score_ones(a_s1), .digit_score_tens(a_s10), .digit_score_hundreds(a_s100),
        .digit_time_ones(a_t1), .digit_time_tens(a_t10), .digit_time_hundreds(a_t100),
        .running(a_run), .time_up(a_up)
    );

    score_time_counter #(.CLKS_PER_SEC(N), .START_TIME_BCD(12'h999)) dut_b (
        .clk(clk), .resetN(resetN), .start(start), .pause(pause),
        .add_points(add_points), .points_bcd(points_bcd), .time_bonus(time_bonus),
        .digit_score_ones(b_s1), .digit_score_tens(b_s10), .digit_score_hundreds(b_s100),
        .digit_time_ones(b_t1), .digit_time_tens(b_t10), .digit_time_hundreds(b_t100),
        .running(b_run), .time_up(b_up)
    );

    // ---------------- reference model (decimal integers) ----------------
    typedef struct {
        int score;
        int tm;
        int cnt;
        bit run;
        bit up;
    } model_t;

    model_t ma, mb;

    function automatic model_t mreset(int t0);
        model_t m;
        m.score = 0; m.tm = t0; m.cnt = 0; m.run = 1'b0; m.up = 1'b0;
        return m;
    endfunction

    function automatic model_t mstep(model_t m, bit st, bit pa, bit ad,
                                     logic [7:0] pts, bit bo, int t0);
        model_t n = m;
        bit     tk;
        int     d;
        if (st) begin
            n = mreset(t0);
            n.run = 1'b1;
        end else if (m.run) begin
            tk = !pa && (m.cnt == N - 1);
            if (ad && !pa && pts[7:4] <= 4'd9 && pts[3:0] <= 4'd9) begin
                n.score = m.score + int'(pts[7:4]) * 10 + int'(pts[3:0]);
                if (n.score > 999) n.score = 999;
            end
            d = tk ? -1 : 0;
            if (BONUS && bo && !pa) d += 10;
            n.tm = m.tm + d;
            if (n.tm < 0)   n.tm = 0;
            if (n.tm > 999) n.tm = 999;
            if (tk && n.tm == 0) begin
                n.run = 1'b0;
                n.up  = 1'b1;
            end
            if (!pa) n.cnt = tk ? 0 : m.cnt + 1;
        end
        return n;
    endfunction

    function automatic logic [11:0] bcd(int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [25:0] mpack(model_t m);
        return {bcd(m.score), bcd(m.tm), m.run, m.up};
    endfunction

    function automatic logic [25:0] act_a();
        return {a_s100, a_s10, a_s1, a_t100, a_t10, a_t1, a_run, a_up};
    endfunction

    function automatic logic [25:0] act_b();
        return {b_s100, b_s10, b_s1, b_t100, b_t10, b_t1, b_run, b_up};
    endfunction

    task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got score=%h time=%h run=%b up=%b, expected score=%h time=%h run=%b up=%b",
                     nm, act[25:14], act[13:2], act[1], act[0],
                     exp[25:14], exp[13:2], exp[1], exp[0]);
        end
    endtask

    task automatic expect_a(input string nm, input logic [11:0] s, input logic [11:0] t,
                            input bit r, input bit u);
        chk(nm, act_a(), {s, t, r, u});
    endtask

    task automatic expect_b(input string nm, input logic [11:0] s, input logic [11:0] t,
                            input bit r, input bit u);
        chk(nm, act_b(), {s, t, r, u});
    endtask

    // One clock of stimulus; both DUTs are checked against the model each cycle.
    task automatic cyc(input bit st, input bit pa, input bit ad,
                       input logic [7:0] pts, input bit bo);
        start = st; pause = pa; add_points = ad; points_bcd = pts; time_bonus = bo;
        @(posedge clk);
        ma = mstep(ma, st, pa, ad, pts, bo, 3);
        mb = mstep(mb, st, pa, ad, pts, bo, 999);
        #1;
        chk("model_a", act_a(), mpack(ma));
        chk("model_b", act_b(), mpack(mb));
        start = 0; pause = 0; add_points = 0; points_bcd = 8'h00; time_bonus = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 8'h00, 0);
    endtask

    // ---------------- directed table for DUT A ----------------
    typedef struct {
        string       nm;
        bit          st, pa, ad;
        logic [7:0]  pts;
        bit          bo;
        logic [11:0] es, et;
        bit          er, eu;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input string nm, input bit st, input bit pa, input bit ad,
                           input logic [7:0] pts, input bit bo,
                           input logic [11:0] es, input logic [11:0] et,
                           input bit er, input bit eu);
        vec_t v;
        v.nm = nm; v.st = st; v.pa = pa; v.ad = ad; v.pts = pts; v.bo = bo;
        v.es = es; v.et = et; v.er = er; v.eu = eu;
        tbl.push_back(v);
    endtask

    initial begin
        // after reset release, idle
        add_vec("post_reset",   0,0,0,8'h00,0, 12'h000,12'h003,0,0);
        add_vec("idle_add_ign", 0,0,1,8'h11,0, 12'h000,12'h003,0,0);
        add_vec("start",        1,0,0,8'h00,0, 12'h000,12'h003,1,0);
        for (int i = 0; i < 3; i++) add_vec("s1_wait", 0,0,0,8'h00,0, 12'h000,12'h003,1,0);
        add_vec("tick1",        0,0,0,8'h00,0, 12'h000,12'h002,1,0);
        for (int i = 0; i < 3; i++) add_vec("s2_wait", 0,0,0,8'h00,0, 12'h000,12'h002,1,0);
        add_vec("tick2",        0,0,0,8'h00,0, 12'h000,12'h001,1,0);
        for (int i = 0; i < 3; i++) add_vec("s3_wait", 0,0,0,8'h00,0, 12'h000,12'h001,1,0);
        add_vec("expire",       0,0,0,8'h00,0, 12'h000,12'h000,0,1);
        for (int i = 0; i < 7; i++) add_vec("exp_hold", 0,0,0,8'h00,0, 12'h000,12'h000,0,1);
        add_vec("exp_add_ign",  0,0,1,8'h05,0, 12'h000,12'h000,0,1);
        add_vec("restart",      1,0,0,8'h00,0, 12'h000,12'h003,1,0);
        add_vec("add_19",       0,0,1,8'h19,0, 12'h019,12'h003,1,0);
        add_vec("add_05_carry", 0,0,1,8'h05,0, 12'h024,12'h003,1,0);
        add_vec("add_1A_ign",   0,0,1,8'h1A,0, 12'h024,12'h003,1,0);
        add_vec("add_99_tick",  0,0,1,8'h99,0, 12'h123,12'h002,1,0);
        add_vec("start_prio",   1,0,1,8'h50,0, 12'h000,12'h003,1,0);
        add_vec("pause_add_ign",0,1,1,8'h99,0, 12'h000,12'h003,1,0);
    end

    // ---------------- main sequence ----------------
    initial begin
        resetN = 1'b0;
        start = 0; pause = 0; add_points = 0; points_bcd = 8'h00; time_bonus = 0;
        ma = mreset(3);
        mb = mreset(999);
        @(posedge clk);
        #1;
        expect_a("reset_a", 12'h000, 12'h003, 0, 0);
        expect_b("reset_b", 12'h000, 12'h999, 0, 0);
        #2 resetN = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].st, tbl[i].pa, tbl[i].ad, tbl[i].pts, tbl[i].bo);
            chk(tbl[i].nm, act_a(), {tbl[i].es, tbl[i].et, tbl[i].er, tbl[i].eu});
            $display("vec %0d %s: score=%h time=%h run=%b up=%b", i, tbl[i].nm,
                     act_a()[25:14], act_a()[13:2], a_run, a_up);
        end

        // pause two cycles into a second: no tick during the pause, tick 2 cycles after release
        cyc(1, 0, 0, 8'h00, 0);
        idle(2);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 8'h00, 0);
            expect_a("pause_hold", 12'h000, 12'h003, 1, 0);
        end
        idle(1);
        expect_a("pause_rel1", 12'h000, 12'h003, 1, 0);
        idle(1);
        expect_a("pause_tick", 12'h000, 12'h002, 1, 0);
        $display("seq pause: time=%h", act_a()[13:2]);

        // bonus at 002 without a tick
        cyc(1, 0, 0, 8'h00, 0);
        idle(4);
        expect_a("pre_bonus", 12'h000, 12'h002, 1, 0);
        cyc(0, 0, 0, 8'h00, 1);
        expect_a("bonus_002", 12'h000, BONUS ? 12'h012 : 12'h002, 1, 0);
        $display("seq bonus: time=%h", act_a()[13:2]);

        // bonus coinciding with the tick at 002
        cyc(1, 0, 0, 8'h00, 0);
        idle(7);
        cyc(0, 0, 0, 8'h00, 1);
        expect_a("bonus_tick", 12'h000, BONUS ? 12'h011 : 12'h001, 1, 0);
        $display("seq bonus+tick: time=%h", act_a()[13:2]);

        // DUT B: score saturation and bonus near the top
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'h99, 0);
        cyc(0, 0, 1, 8'h05, 0);
        expect_b("b_995", 12'h995, 12'h997, 1, 0);
        cyc(0, 0, 1, 8'h07, 0);
        expect_b("b_sat", 12'h999, 12'h996, 1, 0);
        cyc(0, 0, 1, 8'h1A, 0);
        expect_b("b_bad_nib", 12'h999, 12'h996, 1, 0);
        idle(3);
        expect_b("b_t995", 12'h999, 12'h995, 1, 0);
        cyc(0, 0, 0, 8'h00, 1);
        expect_b("b_bonus_sat", 12'h999, BONUS ? 12'h999 : 12'h995, 1, 0);
        $display("seq b: score=%h time=%h", act_b()[25:14], act_b()[13:2]);

        // asynchronous reset while running
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h42, 0);
        #2 resetN = 1'b0;
        #1;
        expect_a("async_rst_a", 12'h000, 12'h003, 0, 0);
        expect_b("async_rst_b", 12'h000, 12'h999, 0, 0);
        ma = mreset(3);
        mb = mreset(999);
        #1 resetN = 1'b1;
        idle(2);
        expect_a("after_rst", 12'h000, 12'h003, 0, 0);
        $display("seq async reset: run=%b up=%b", a_run, a_up);

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic [7:0] p;
            if ($urandom_range(0, 3) == 0) p = 8'($urandom);
            else p = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0, p, $urandom_range(0, 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/score_time_counter.md
# score_time_counter

Game-state counter that produces the six BCD digits consumed by the on-screen number bitmap stage: a 3-digit score and a 3-digit countdown timer. It sits upstream of the digit renderer and is driven by game logic through single-cycle event pulses. It owns the one-second prescaler and the game run/expire state machine, and asserts `time_up` when the countdown reaches zero.

## Interface
Parameters:
- `CLKS_PER_SEC`, 31_500_000: clock cycles per timer second; legal range ≥ 2.
- `START_TIME_BCD`, 12'h120: timer load value, three BCD nibbles; each nibble must be ≤ 9.

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  pulse: clear score, load timer, enter RUNNING.
- `pause`  in  1  level: freeze timer and prescaler while high.
- `add_points`  in  1  pulse: add `points_bcd` to score.
- `points_bcd`  in  8  two BCD digits, value 00–99.
- `time_bonus`  in  1  pulse: add 10 s to timer. Honoured only under `TIMER_BONUS_EN`.
- `digit_score_ones`, `digit_score_tens`, `digit_score_hundreds`  out  4 each  score BCD digits.
- `digit_time_ones`, `digit_time_tens`, `digit_time_hundreds`  out  4 each  timer BCD digits.
- `running`  out  1  high in RUNNING.
- `time_up`  out  1  high in EXPIRED.

## Operation
- State machine states: IDLE, RUNNING, EXPIRED.
  - IDLE → RUNNING on `start`.
  - RUNNING → EXPIRED when a tick decrements the timer to 000.
  - EXPIRED → RUNNING on `start`.
  - RUNNING → RUNNING on `start` (restart).
- On `start`, in any state:
  - score := 000
  - timer := `START_TIME_BCD`
  - prescaler := 0
  - `start` has priority over every other input in the same cycle.
- Prescaler:
  - Counts 0..`CLKS_PER_SEC`−1 only in RUNNING with `pause` low.
  - The tick fires on the cycle the count equals `CLKS_PER_SEC`−1; the count then wraps to 0.
  - Holds its value while paused.
- Tick: decrement the timer by 1 in BCD with borrow across digits.
  - Example: 100 → 099.
  - Timer never goes below 000.
- Score: `add_points` in RUNNING adds `points_bcd` in BCD with carry, saturating at 999.
  - `add_points` is ignored in IDLE and EXPIRED, and ignored while `pause` is high.
  - If any `points_bcd` nibble is > 9, the whole event is ignored.
- `add_points` and tick in the same cycle are independent; both take effect.
- Score and timer digits hold their values in EXPIRED until the next `start`.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N (1-cycle latency).
- `time_up` rises on the same edge on which the timer digits become 000.
- Reset values:
  - score digits 0,0,0
  - timer digits = `START_TIME_BCD` nibbles
  - `running` 0, `time_up` 0
  - state IDLE, prescaler 0
- Reset asserted mid-operation forces all reset values immediately (asynchronous); no event is lost or replayed after release.
- With `CLKS_PER_SEC`=N, the first tick after `start` at edge S occurs at edge S+N.

## Configuration
- Macro `TIMER_BONUS_EN`.
- Defined:
  - `time_bonus` in RUNNING, with `pause` low, adds 010 to the timer, saturating at 999.
  - If a tick and a bonus occur in the same cycle, the net change is +009, computed in one step.
  - A bonus on the same cycle a tick would reach 000 prevents expiry.
- Undefined: the `time_bonus` port is present but ignored; no bonus logic is synthesized.

## Structure
- Package `score_time_pkg`:
  - `bcd_digit_t` (logic [3:0])
  - `bcd3_t` (packed struct: hundreds, tens, ones)
  - state enum `game_state_e`
  - constants `BCD3_MAX` = 999 and `BCD3_ZERO`
- Sub-module `bcd3_addsub`: combinational 3-digit BCD add/subtract of a 3-digit operand, with saturation at 999 and floor at 000. Instantiated once for the score and once for the timer.

## Test plan
All scenarios use `CLKS_PER_SEC`=4 and `START_TIME_BCD`=12'h003 unless stated.
- Reset, then release → score 000, time 003, `running`=0, `time_up`=0. Assert reset while RUNNING → same values immediately, without waiting for a clock edge.
- `start`, then run 12 cycles → time 002 after 4 cycles, 001 after 8, 000 after 12 with `time_up`=1 and `running`=0 on the same edge. A further 8 cycles → digits unchanged.
- In RUNNING with score 995:
  - `points_bcd`=8'h07 → score 999 (saturates).
  - `points_bcd`=8'h1A → ignored.
  - From score 019, `points_bcd`=8'h05 → 024.
- `pause` high for 10 cycles starting 2 cycles into a second → time unchanged during the pause; after release the next tick arrives 2 cycles later.
- `start` and `add_points` (8'h50) in the same cycle from score 123 → score 000 and time 003.
- With `TIMER_BONUS_EN` defined: bonus at time 002 → 012; bonus coinciding with a tick at 002 → 011; bonus with the timer at 995 → 999. With the macro undefined: a bonus at 002 → 002.
